// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - RV32E multi-cycle sequencer: IF/EX/MEM/WB stepping, shared memory port, commit gating
module core_seq_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_wen_reg,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_halt,
   input  logic             dec_illegal,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_sel,
   output logic             mem_wen,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             reg_we,
   output logic             pc_we,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int unsigned WT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IF,
      S_EX,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WT_W-1:0]   wait_cnt;
   logic              err_q;
   logic              err_set;
   logic [CNT_W-1:0]  cyc_q;
   logic [CNT_W-1:0]  inst_q;
   logic              req_cyc;
   logic              timed_out;
   logic              active;

   logic mem_req_c, mem_sel_c, mem_wen_c, ir_we_c, mdr_we_c, reg_we_c, pc_we_c;

   assign req_cyc   = (state == S_IF) || (state == S_MEM);
   assign active    = (state == S_IF) || (state == S_EX) || (state == S_MEM) || (state == S_WB);
   // This cycle would be the TIMEOUT-th consecutive cycle without an ack.
   assign timed_out = (TIMEOUT != 0) && req_cyc && !mem_ack &&
                      ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      mem_req_c = 1'b0;
      mem_sel_c = 1'b0;
      mem_wen_c = 1'b0;
      ir_we_c   = 1'b0;
      mdr_we_c  = 1'b0;
      reg_we_c  = 1'b0;
      pc_we_c   = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_IF;
         S_IF: begin
            mem_req_c = 1'b1;
            if (mem_ack) begin
               ir_we_c   = 1'b1;
               state_nxt = S_EX;
            end else if (timed_out) begin
               err_set   = 1'b1;
               state_nxt = S_HALT;
            end
         end
         S_EX: begin
            if (dec_illegal) begin
               err_set   = 1'b1;
               state_nxt = S_HALT;
            end else if (dec_halt) begin
               state_nxt = S_HALT;
            end else if (dec_load || dec_store) begin
               state_nxt = S_MEM;
            end else begin
               reg_we_c  = dec_wen_reg;
               pc_we_c   = 1'b1;
               state_nxt = S_IF;
            end
         end
         S_MEM: begin
            mem_req_c = 1'b1;
            mem_sel_c = 1'b1;
            mem_wen_c = dec_store;
            if (mem_ack) begin
               if (dec_load) begin
                  mdr_we_c  = 1'b1;
                  state_nxt = S_WB;
               end else begin
                  pc_we_c   = 1'b1;
                  state_nxt = S_IF;
               end
            end else if (timed_out) begin
               err_set   = 1'b1;
               state_nxt = S_HALT;
            end
         end
         S_WB: begin
            reg_we_c  = 1'b1;
            pc_we_c   = 1'b1;
            state_nxt = S_IF;
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         err_q    <= 1'b0;
         cyc_q    <= '0;
         inst_q   <= '0;
      end else begin
         state    <= state_nxt;
         err_q    <= err_q | err_set;
         wait_cnt <= (req_cyc && !mem_ack) ? wait_cnt + WT_W'(1) : '0;
         if (active) begin
            cyc_q <= cyc_q + CNT_W'(1);
         end
         if (pc_we_c) begin
            inst_q <= inst_q + CNT_W'(1);
         end
      end
   end

   // Outputs are forced low while rst is high so an in-flight request drops at once.
   assign mem_req     = mem_req_c & ~rst;
   assign mem_sel     = mem_sel_c & ~rst;
   assign mem_wen     = mem_wen_c & ~rst;
   assign ir_we       = ir_we_c   & ~rst;
   assign mdr_we      = mdr_we_c  & ~rst;
   assign reg_we      = reg_we_c  & ~rst;
   assign pc_we       = pc_we_c   & ~rst;
   assign halted      = (state == S_HALT) & ~rst;
   assign err         = err_q & ~rst;
   assign cyc_cnt     = rst ? '0 : cyc_q;
   assign instret_cnt = rst ? '0 : inst_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl against a per-instruction cycle-trace model
module tb_core_seq_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dec_wen_reg = 1'b0, dec_load = 1'b0, dec_store = 1'b0;
   logic        dec_halt = 1'b0, dec_illegal = 1'b0, mem_ack = 1'b0;
   logic        mem_req, mem_sel, mem_wen, ir_we, mdr_we, reg_we, pc_we, halted, err;
   logic [31:0] cyc_cnt, instret_cnt;
   logic [6:0]  strobes;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_cyc = 0;
   logic [31:0] exp_inst = 0;
   logic        k_wen = 0, k_load = 0, k_store = 0, k_halt = 0, k_ill = 0;

   always #5 clk = ~clk;

   core_seq_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .dec_wen_reg(dec_wen_reg), .dec_load(dec_load), .dec_store(dec_store),
      .dec_halt(dec_halt), .dec_illegal(dec_illegal), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_wen(mem_wen),
      .ir_we(ir_we), .mdr_we(mdr_we), .reg_we(reg_we), .pc_we(pc_we),
      .halted(halted), .err(err), .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
   );

   // Bit order: req, sel, wen, ir_we, mdr_we, reg_we, pc_we
   assign strobes = {mem_req, mem_sel, mem_wen, ir_we, mdr_we, reg_we, pc_we};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One active cycle: drive inputs, check the expected strobe set and counters.
   task automatic cyc(input logic ack, input logic [6:0] ev, input string tag);
      @(negedge clk);
      dec_wen_reg = k_wen; dec_load = k_load; dec_store = k_store;
      dec_halt = k_halt; dec_illegal = k_ill; mem_ack = ack;
      #1;
      check({tag, "/strobes"}, 32'(strobes), 32'(ev));
      check({tag, "/cyc_cnt"}, cyc_cnt, exp_cyc);
      check({tag, "/instret"}, instret_cnt, exp_inst);
      exp_cyc++;
      if (ev[0]) exp_inst++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; mem_ack = 1'b1;
      #1;
      check("rst/strobes", 32'(strobes), 32'd0);
      check("rst/halted", 32'(halted), 32'd0);
      check("rst/err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check("rst/cyc_cnt", cyc_cnt, 32'd0);
      check("rst/instret", instret_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b0;
      k_wen = 0; k_load = 0; k_store = 0; k_halt = 0; k_ill = 0;
      dec_wen_reg = 0; dec_load = 0; dec_store = 0; dec_halt = 0; dec_illegal = 0;
      #1;
      check("idle/strobes", 32'(strobes), 32'd0);
      check("idle/halted", 32'(halted), 32'd0);
      exp_cyc = 0;
      exp_inst = 0;
   endtask

   task automatic halt_check(input logic exp_err, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mem_ack = 1'($urandom % 2);
         #1;
         check("halt/strobes", 32'(strobes), 32'd0);
         check("halt/halted", 32'(halted), 32'd1);
         check("halt/err", 32'(err), 32'(exp_err));
         check("halt/cyc_cnt", cyc_cnt, exp_cyc);
         check("halt/instret", instret_cnt, exp_inst);
      end
      mem_ack = 1'b0;
   endtask

   // Request phase: w wait cycles then ack; w >= TO means the timeout fires first.
   task automatic req_phase(input int w, input logic [6:0] wait_v, input logic [6:0] ack_v,
                            input string tag, output bit to);
      if (w >= TO) begin
         repeat (TO) cyc(1'b0, wait_v, {tag, "_wait"});
         to = 1'b1;
      end else begin
         repeat (w) cyc(1'b0, wait_v, {tag, "_wait"});
         cyc(1'b1, ack_v, {tag, "_ack"});
         to = 1'b0;
      end
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal
   task automatic run_instr(input int kind, input logic wen, input int wf, input int wd, input int hcyc);
      bit to;
      k_wen = wen; k_load = (kind == 1); k_store = (kind == 2);
      k_halt = (kind == 3); k_ill = (kind == 4);
      req_phase(wf, 7'b1000000, 7'b1001000, "if", to);
      if (to) begin
         halt_check(1'b1, hcyc);
         do_reset();
         return;
      end
      cyc(1'($urandom % 2), (kind == 0) ? {5'b0, wen, 1'b1} : 7'b0, "ex");
      if (kind >= 3) begin
         halt_check(kind == 4, hcyc);
         do_reset();
         return;
      end
      if (kind == 1 || kind == 2) begin
         if (kind == 2) req_phase(wd, 7'b1110000, 7'b1110001, "st", to);
         else           req_phase(wd, 7'b1100000, 7'b1100100, "ld", to);
         if (to) begin
            halt_check(1'b1, hcyc);
            do_reset();
            return;
         end
         if (kind == 1) cyc(1'($urandom % 2), 7'b0000011, "wb");
      end
      @(posedge clk);
      #1;
      check("end/cyc_cnt", cyc_cnt, exp_cyc);
      check("end/instret", instret_cnt, exp_inst);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1);
   end

   initial begin
      bit to;
      int r;
      do_reset();
      run_instr(0, 1'b1, 0, 0, 5);
      check("alu/cyc2", exp_cyc, 32'd2);
      do_reset();
      run_instr(1, 1'b0, 2, 3, 5);
      check("load/cyc9", exp_cyc, 32'd9);
      do_reset();
      run_instr(2, 1'b0, 0, 0, 5);
      check("store/cyc3", exp_cyc, 32'd3);
      do_reset();
      run_instr(3, 1'b0, 0, 0, 20);
      run_instr(4, 1'b0, 1, 0, 20);
      run_instr(0, 1'b1, 5, 0, 5);
      run_instr(0, 1'b1, 3, 0, 5);
      run_instr(1, 1'b0, 0, 4, 5);
      run_instr(2, 1'b0, 1, 3, 5);

      // Reset while a data request is pending.
      k_wen = 0; k_load = 1; k_store = 0; k_halt = 0; k_ill = 0;
      req_phase(0, 7'b1000000, 7'b1001000, "if", to);
      cyc(1'b0, 7'b0, "ex");
      cyc(1'b0, 7'b1100000, "ld_wait");
      cyc(1'b0, 7'b1100000, "ld_wait");
      do_reset();
      run_instr(0, 1'b0, 0, 0, 5);

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom % 16);
         run_instr((r < 7) ? 0 : (r < 10) ? 1 : (r < 13) ? 2 : (r == 13) ? 3 : (r == 14) ? 4 : 0,
                   1'($urandom % 2),
                   ($urandom % 16 == 0) ? 5 : int'($urandom_range(0, 3)),
                   ($urandom % 16 == 0) ? 6 : int'($urandom_range(0, 3)),
                   3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
